expr_pipe_eval: RTL and testbench
=================================

Name: expr_pipe_eval

Overview:
- Parametrised, pipelined successor to the combinational vloghammer expression blocks.
- Evaluates one selectable signed/unsigned expression per transaction on W-bit operands, through a STAGES-deep registered pipeline with valid/ready handshake.
- Keeps a transaction counter so the regression bench can cross-check pipelined results against its combinational golden model.

Parameters:
- W, 6, operand/result width (2..32).
- STAGES, 2, pipeline depth in cycles (1..8).
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block accepts operands this cycle.
- op  input  3  operation select.
- sgn  input  1  1 = operands signed, 0 = unsigned.
- a  input  W  operand A.
- b  input  W  operand B / shift amount.
- c  input  W  select condition for SEL.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- y  output  W  result.
- zero  output  1  y == 0.
- out_cnt  output  CNT_W  count of results consumed.
- sig  output  W  signature (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_n low): all stage valids 0, out_valid 0, y 0, zero 0, out_cnt 0, sig 0; in_ready 1 once reset is released.
- Stall is global: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - When stall is 1, every stage register holds.
  - Bubbles are not compressed.
- Accept: in_valid & in_ready captures op/sgn/a/b/c into stage 1 with valid 1. in_valid & ~in_ready is ignored; the source must hold its data.
- Latency: exactly STAGES cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- The result is computed in stage 1; later stages only delay it.
- Op codes (all results truncated to the low W bits):
  - 0 ADD: a+b mod 2^W.
  - 1 SUB: a-b mod 2^W.
  - 2 MUL: low W bits of a*b; identical for signed and unsigned.
  - 3 SHL: a << b, with b treated as unsigned; b >= W gives 0.
  - 4 SHR: sgn=1 gives arithmetic shift a >>> b; sgn=0 gives logical shift. b is unsigned. b >= W gives all copies of a[W-1] (sgn=1) or 0 (sgn=0).
  - 5 LT: y = {0..0, a<b}, compared signed if sgn else unsigned.
  - 6 EQ: y = {0..0, a==b}.
  - 7 SEL: y = (|c) ? a : b.
- zero is registered alongside y and equals (y == 0).
- out_cnt increments on out_valid & out_ready and wraps from 2^CNT_W-1 to 0.
- Simultaneous events:
  - Accept and output handshake in the same cycle advance the pipe normally.
  - When out_ready rises, the stall releases in that same cycle.
- Reset mid-operation discards all in-flight transactions; no partial result is emitted.

Optional Feature:
- Macro: EXPR_PIPE_SIG_EN.
- Defined: sig is a W-bit register, reset 0. On each output handshake it updates to {sig[W-2:0], sig[W-1]} ^ y (rotate-left then XOR).
- Not defined: sig is constant 0, with no registers inferred.
- All other behaviour is identical either way.

Test Plan:
- W=6, STAGES=2, out_ready=1; ADD a=63, b=1 -> y=0, zero=1, out_valid exactly 2 cycles after accept, out_cnt=1.
- SUB sgn=1 a=6'b111101 (-3), b=2 -> y=6'b111011 (-5).
- SHR a=6'b100000, b=2:
  - sgn=1 -> 6'b111000.
  - sgn=0 -> 6'b001000.
  - b=7, sgn=1 -> 6'b111111.
- LT a=6'b111111, b=1: sgn=1 -> y=1; sgn=0 -> y=0.
- Back-to-back stream of 4 ops with out_ready low for cycles 3-5:
  - in_ready must be 0 exactly while out_valid & ~out_ready.
  - No result is lost or duplicated, and results stay in order.
  - out_cnt=4 at the end.
- Reset mid-stream with 2 ops in flight, then release:
  - out_valid stays 0, out_cnt=0, sig=0.
  - The next op's result appears after 2 cycles.
  - With EXPR_PIPE_SIG_EN, results 6'd5 then 6'd3 give sig=6'b001001.

Source files
------------

// File: rtl/expr_pipe_eval.sv
// Pipelined selectable-expression evaluator with valid/ready handshake and result counter.
// Optional output signature register is enabled by defining EXPR_PIPE_SIG_EN.
module expr_pipe_eval #(
  parameter int unsigned W      = 6,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             sgn,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     y,
  output logic             zero,
  output logic [CNT_W-1:0] out_cnt,
  output logic [W-1:0]     sig
);

  localparam logic [W-1:0] WLIM = W'(W);

  logic                stall;
  logic                fire;
  logic [W-1:0]        res_c;
  logic                lt_c;
  logic                big_c;
  logic signed [W-1:0] as_s;
  logic signed [W-1:0] bs_s;
  logic [W-1:0]        y_q [STAGES];
  logic [STAGES-1:0]   v_q;
  logic [STAGES-1:0]   z_q;
  logic [CNT_W-1:0]    cnt_q;

  assign stall    = v_q[STAGES-1] & ~out_ready;
  assign fire     = v_q[STAGES-1] & out_ready;
  assign in_ready = ~stall;

  assign as_s = $signed(a);
  assign bs_s = $signed(b);

  // Stage-1 expression evaluation; shift amounts are always unsigned.
  always_comb begin
    res_c = '0;
    big_c = (b >= WLIM);
    lt_c  = sgn ? (as_s < bs_s) : (a < b);
    case (op)
      3'd0: res_c = a + b;
      3'd1: res_c = a - b;
      3'd2: res_c = a * b;
      3'd3: res_c = big_c ? '0 : (a << b);
      3'd4: begin
        if (sgn) res_c = big_c ? {W{a[W-1]}} : W'(as_s >>> b);
        else     res_c = big_c ? '0 : (a >> b);
      end
      3'd5: res_c = {{(W-1){1'b0}}, lt_c};
      3'd6: res_c = {{(W-1){1'b0}}, (a == b)};
      3'd7: res_c = (|c) ? a : b;
      default: res_c = '0;
    endcase
  end

  // Delay line; a global stall freezes every stage, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      z_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) y_q[i] <= '0;
    end else if (!stall) begin
      v_q[0] <= in_valid;
      if (in_valid) begin
        y_q[0] <= res_c;
        z_q[0] <= (res_c == '0);
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        v_q[i] <= v_q[i-1];
        y_q[i] <= y_q[i-1];
        z_q[i] <= z_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (fire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign out_valid = v_q[STAGES-1];
  assign y         = y_q[STAGES-1];
  assign zero      = z_q[STAGES-1];
  assign out_cnt   = cnt_q;

`ifdef EXPR_PIPE_SIG_EN
  logic [W-1:0] sig_q;

  // Rotate-left then fold in each consumed result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else if (fire) sig_q <= {sig_q[W-2:0], sig_q[W-1]} ^ y_q[STAGES-1];
  end

  assign sig = sig_q;
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_expr_pipe_eval.sv
// Randomised self-checking bench for expr_pipe_eval against a queue-based transaction model.
module tb_expr_pipe_eval;
  localparam int W = 6;
  localparam int STAGES = 2;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [2:0] op = '0;
  logic sgn = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] y;
  logic zero;
  logic [CNT_W-1:0] out_cnt;
  logic [W-1:0] sig;

  int n_checks = 0;
  int n_pass = 0;

  // Model: each accepted transaction carries its result and how many unstalled edges it has seen.
  logic [W-1:0] exp_q[$];
  int           age_q[$];
  int           cnt_m = 0;
  logic [W-1:0] sig_m = '0;

  typedef struct {
    bit ov, ir, zo, e_ov, e_ir, acc, fire;
    logic [W-1:0] y, sig, e_y, e_sig;
    logic [CNT_W-1:0] cnt, e_cnt;
  } snap_t;

  typedef struct {
    logic [2:0] op;
    bit s;
    logic [W-1:0] a, b, c, e;
  } vec_t;

  expr_pipe_eval #(.W(W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sgn(sgn), .a(a), .b(b), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero),
    .out_cnt(out_cnt), .sig(sig)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_eval(input logic [2:0] o, input bit s,
                                            input logic [W-1:0] aa, bb, cc);
    int ia, ib, sa, sb, r;
    ia = int'(aa);
    ib = int'(bb);
    sa = (s && aa[W-1]) ? ia - (1 << W) : ia;
    sb = (s && bb[W-1]) ? ib - (1 << W) : ib;
    case (o)
      3'd0: r = ia + ib;
      3'd1: r = ia - ib;
      3'd2: r = ia * ib;
      3'd3: r = (ib >= W) ? 0 : (ia << ib);
      3'd4: if (s) r = (ib >= W) ? ((sa < 0) ? -1 : 0) : (sa >>> ib);
            else   r = (ib >= W) ? 0 : (ia >> ib);
      3'd5: r = s ? int'(sa < sb) : int'(ia < ib);
      3'd6: r = int'(ia == ib);
      default: r = (cc != 0) ? ia : ib;
    endcase
    return W'(r);
  endfunction

  function automatic logic [W-1:0] rot(input logic [W-1:0] v);
    return (v << 1) | (v >> (W - 1));
  endfunction

  // Drive one cycle from a negedge, sample before the edge, advance the model, return at next negedge.
  task automatic tick(input bit iv, input logic [2:0] o, input bit s,
                      input logic [W-1:0] aa, bb, cc, input bit ordy, output snap_t t);
    in_valid = iv; op = o; sgn = s; a = aa; b = bb; c = cc; out_ready = ordy;
    #1;
    t.ov = out_valid; t.ir = in_ready; t.zo = zero; t.y = y; t.sig = sig; t.cnt = out_cnt;
    t.e_ov  = (age_q.size() > 0) && (age_q[0] >= STAGES);
    t.e_y   = t.e_ov ? exp_q[0] : '0;
    t.e_ir  = !(t.e_ov && !ordy);
    t.e_cnt = CNT_W'(cnt_m);
    t.e_sig = sig_m;
    t.fire  = t.e_ov && ordy;
    t.acc   = iv && t.e_ir;
    if (t.fire) begin
`ifdef EXPR_PIPE_SIG_EN
      sig_m = rot(sig_m) ^ exp_q[0];
`endif
      cnt_m = (cnt_m + 1) % (1 << CNT_W);
      void'(exp_q.pop_front());
      void'(age_q.pop_front());
    end
    if (t.e_ir) foreach (age_q[i]) age_q[i]++;
    if (t.acc) begin
      exp_q.push_back(ref_eval(o, s, aa, bb, cc));
      age_q.push_back(1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); age_q.delete();
    cnt_m = 0; sig_m = '0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_ovalid: got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (y !== '0) $display("FAIL reset_y: got %0d want 0", y); else n_pass++;
    n_checks++; if (zero !== 1'b0) $display("FAIL reset_zero: got %0b want 0", zero); else n_pass++;
    n_checks++; if (out_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", out_cnt); else n_pass++;
    n_checks++; if (sig !== '0) $display("FAIL reset_sig: got %0d want 0", sig); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_iready: got %0b want 1", in_ready); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_directed();
    vec_t vt[12];
    snap_t t;
    int n;
    vt[0]  = '{3'd0, 1'b0, 6'd63, 6'd1, 6'd0, 6'd0};
    vt[1]  = '{3'd1, 1'b1, 6'b111101, 6'd2, 6'd0, 6'b111011};
    vt[2]  = '{3'd4, 1'b1, 6'b100000, 6'd2, 6'd0, 6'b111000};
    vt[3]  = '{3'd4, 1'b0, 6'b100000, 6'd2, 6'd0, 6'b001000};
    vt[4]  = '{3'd4, 1'b1, 6'b100000, 6'd7, 6'd0, 6'b111111};
    vt[5]  = '{3'd5, 1'b1, 6'b111111, 6'd1, 6'd0, 6'd1};
    vt[6]  = '{3'd5, 1'b0, 6'b111111, 6'd1, 6'd0, 6'd0};
    vt[7]  = '{3'd3, 1'b0, 6'd5, 6'd6, 6'd0, 6'd0};
    vt[8]  = '{3'd2, 1'b1, 6'd63, 6'd63, 6'd0, 6'd1};
    vt[9]  = '{3'd6, 1'b0, 6'd9, 6'd9, 6'd0, 6'd1};
    vt[10] = '{3'd7, 1'b0, 6'd1, 6'd2, 6'd0, 6'd2};
    vt[11] = '{3'd7, 1'b0, 6'd1, 6'd2, 6'd4, 6'd1};
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, vt[i].op, vt[i].s, vt[i].a, vt[i].b, vt[i].c, 1'b1, t);
      n_checks++; if (t.ir !== 1'b1) $display("FAIL dir_iready[%0d]: got %0b want 1", i, t.ir); else n_pass++;
      n = 0;
      do begin
        tick(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, t);
        n++;
      end while (!t.ov && n < 10);
      n_checks++; if (n !== STAGES) $display("FAIL dir_latency[%0d]: got %0d want %0d", i, n, STAGES); else n_pass++;
      n_checks++; if (t.y !== vt[i].e) $display("FAIL dir_y[%0d]: got %b want %b", i, t.y, vt[i].e); else n_pass++;
      n_checks++; if (t.zo !== (vt[i].e == '0)) $display("FAIL dir_zero[%0d]: got %0b want %0b", i, t.zo, vt[i].e == '0); else n_pass++;
      n_checks++; if (t.cnt !== CNT_W'(i)) $display("FAIL dir_cnt[%0d]: got %0d want %0d", i, t.cnt, i); else n_pass++;
    end
    tick(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, t);
    n_checks++; if (t.cnt !== CNT_W'(12)) $display("FAIL dir_cnt_end: got %0d want 12", t.cnt); else n_pass++;
    n_checks++; if (t.ov !== 1'b0) $display("FAIL dir_idle_ovalid: got %0b want 0", t.ov); else n_pass++;
  endtask

  task automatic test_back_to_back();
    snap_t t;
    logic [2:0] o[4];
    logic [W-1:0] av[4], bv[4];
    int sent = 0, fired = 0, k = 0;
    bit ordy;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      o[i] = 3'($urandom_range(0, 7)); av[i] = W'($urandom); bv[i] = W'($urandom);
    end
    while (fired < 4 && k < 40) begin
      ordy = !(k >= 3 && k <= 5);
      if (sent < 4) tick(1'b1, o[sent], 1'b1, av[sent], bv[sent], av[sent], ordy, t);
      else          tick(1'b0, 3'd0, 1'b0, '0, '0, '0, ordy, t);
      if (t.acc) sent++;
      if (t.fire) fired++;
      n_checks++; if (t.ov !== t.e_ov) $display("FAIL b2b_ovalid[%0d]: got %0b want %0b", k, t.ov, t.e_ov); else n_pass++;
      n_checks++; if (t.ir !== t.e_ir) $display("FAIL b2b_iready[%0d]: got %0b want %0b", k, t.ir, t.e_ir); else n_pass++;
      if (t.e_ov) begin
        n_checks++; if (t.y !== t.e_y) $display("FAIL b2b_y[%0d]: got %0d want %0d", k, t.y, t.e_y); else n_pass++;
      end
      k++;
    end
    n_checks++; if (fired !== 4) $display("FAIL b2b_timeout: got %0d results want 4", fired); else n_pass++;
    tick(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, t);
    n_checks++; if (t.cnt !== CNT_W'(4)) $display("FAIL b2b_cnt: got %0d want 4", t.cnt); else n_pass++;
  endtask

  task automatic test_random();
    snap_t t;
    logic [2:0] o;
    bit s;
    logic [W-1:0] av, bv, cv;
    int k = 0;
    o = 3'($urandom_range(0, 7)); s = 1'($urandom); av = W'($urandom);
    bv = W'($urandom_range(0, 8)); cv = W'($urandom_range(0, 1));
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 3) != 0), o, s, av, bv, cv, 1'($urandom_range(0, 3) != 0), t);
      if (t.acc) begin
        o = 3'($urandom_range(0, 7)); s = 1'($urandom); av = W'($urandom);
        bv = $urandom_range(0, 1) ? W'($urandom_range(0, 8)) : W'($urandom);
        cv = W'($urandom_range(0, 1) * $urandom);
      end
      n_checks++; if (t.ov !== t.e_ov) $display("FAIL rnd_ovalid[%0d]: got %0b want %0b", i, t.ov, t.e_ov); else n_pass++;
      n_checks++; if (t.ir !== t.e_ir) $display("FAIL rnd_iready[%0d]: got %0b want %0b", i, t.ir, t.e_ir); else n_pass++;
      n_checks++; if (t.cnt !== t.e_cnt) $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, t.cnt, t.e_cnt); else n_pass++;
      n_checks++; if (t.sig !== t.e_sig) $display("FAIL rnd_sig[%0d]: got %0d want %0d", i, t.sig, t.e_sig); else n_pass++;
      if (t.e_ov) begin
        n_checks++; if (t.y !== t.e_y) $display("FAIL rnd_y[%0d]: got %0d want %0d", i, t.y, t.e_y); else n_pass++;
        n_checks++; if (t.zo !== (t.e_y == '0)) $display("FAIL rnd_zero[%0d]: got %0b want %0b", i, t.zo, t.e_y == '0); else n_pass++;
      end
    end
    while (exp_q.size() > 0 && k < 20) begin
      tick(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, t);
      k++;
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL rnd_drain: got %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    snap_t t;
    int n;
    logic [W-1:0] want_sig;
    tick(1'b1, 3'd0, 1'b0, 6'd10, 6'd11, '0, 1'b1, t);
    tick(1'b1, 3'd1, 1'b0, 6'd20, 6'd3, '0, 1'b1, t);
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_ovalid: got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (out_cnt !== '0) $display("FAIL mid_cnt: got %0d want 0", out_cnt); else n_pass++;
    n_checks++; if (sig !== '0) $display("FAIL mid_sig: got %0d want 0", sig); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); age_q.delete();
    cnt_m = 0; sig_m = '0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, t);
      n_checks++; if (t.ov !== 1'b0) $display("FAIL mid_ghost[%0d]: got %0b want 0", i, t.ov); else n_pass++;
    end
    tick(1'b1, 3'd0, 1'b0, 6'd2, 6'd3, '0, 1'b1, t);
    n = 0;
    do begin
      tick(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, t);
      n++;
    end while (!t.ov && n < 10);
    n_checks++; if (n !== STAGES) $display("FAIL mid_latency: got %0d want %0d", n, STAGES); else n_pass++;
    n_checks++; if (t.y !== 6'd5) $display("FAIL mid_y: got %0d want 5", t.y); else n_pass++;
    tick(1'b1, 3'd0, 1'b0, 6'd1, 6'd2, '0, 1'b1, t);
    for (int i = 0; i < 3; i++) tick(1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, t);
`ifdef EXPR_PIPE_SIG_EN
    want_sig = 6'b001001;
`else
    want_sig = '0;
`endif
    n_checks++; if (t.sig !== want_sig) $display("FAIL mid_sig_end: got %b want %b", t.sig, want_sig); else n_pass++;
    n_checks++; if (t.cnt !== CNT_W'(2)) $display("FAIL mid_cnt_end: got %0d want 2", t.cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    do_reset();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
